// File: rtl/neuron_seq_pkg.sv
// Shared types and constants for the neuron core sequencer.
// Contents: sequencer state enum, 2-bit synapse type codes, potential width,
// and a helper that widens a synapse type into the datapath weight select.
package neuron_seq_pkg;

  localparam int unsigned POT_W = 8;
  localparam int unsigned SYN_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    STALL = 2'd2
  } seq_state_e;

  localparam logic [SYN_W-1:0] SYN_TYPE_0 = 2'd0;
  localparam logic [SYN_W-1:0] SYN_TYPE_1 = 2'd1;
  localparam logic [SYN_W-1:0] SYN_TYPE_2 = 2'd2;
  localparam logic [SYN_W-1:0] SYN_TYPE_3 = 2'd3;

  function automatic logic [POT_W-1:0] syn_weight_sel(input logic [SYN_W-1:0] t);
    return {{(POT_W-SYN_W){1'b0}}, t};
  endfunction

endpackage

// File: rtl/spike_fifo.sv
// Synchronous first-word-fall-through FIFO for output spike events.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   push_i, data_i : write request and data
//   pop_i          : consume head entry (ignored when empty)
//   data_o         : head entry, '0 when empty
//   full_o, empty_o: occupancy flags
// A push while full is accepted when a pop happens in the same cycle.
module spike_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked by empty_o.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/neuron_core_sequencer.sv
// Event-driven neuron core front end. Accepts axon spike events, latches the
// axon's connectivity row and synapse type, and walks neurons one per cycle
// through an external combinational neuron datapath, writing back potentials
// and queuing output spikes in a FWFT FIFO.
// Ports:
//   clk_i, rst_i                        : clock, synchronous active-high reset
//   spike_valid_i/spike_axon_i/spike_ready_o : input event handshake
//   cfg_we_i/cfg_axon_i/cfg_mask_i/cfg_type_i : connectivity table write
//   nb_potential_o/nb_weight_select_o/nb_enable_o : to datapath (0 when idle)
//   nb_new_potential_i/nb_spike_i       : datapath result, same cycle
//   out_valid_o/out_neuron_o/out_ready_i: output spike event stream
//   rd_neuron_i/rd_potential_o          : debug potential read
//   busy_o                              : high outside IDLE
//   spike_count_o                       : saturating push counter
// Optional feature: define NEURON_SEQ_SPIKE_CNT_EN to build the spike
// counter; otherwise spike_count_o is tied to 0.
module neuron_core_sequencer
  import neuron_seq_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 16,
  parameter int unsigned NUM_AXONS   = 16,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           spike_valid_i,
  input  logic [$clog2(NUM_AXONS)-1:0]   spike_axon_i,
  output logic                           spike_ready_o,
  input  logic                           cfg_we_i,
  input  logic [$clog2(NUM_AXONS)-1:0]   cfg_axon_i,
  input  logic [NUM_NEURONS-1:0]         cfg_mask_i,
  input  logic [1:0]                     cfg_type_i,
  output logic [7:0]                     nb_potential_o,
  output logic [7:0]                     nb_weight_select_o,
  output logic                           nb_enable_o,
  input  logic [7:0]                     nb_new_potential_i,
  input  logic                           nb_spike_i,
  output logic                           out_valid_o,
  output logic [$clog2(NUM_NEURONS)-1:0] out_neuron_o,
  input  logic                           out_ready_i,
  input  logic [$clog2(NUM_NEURONS)-1:0] rd_neuron_i,
  output logic [7:0]                     rd_potential_o,
  output logic                           busy_o,
  output logic [15:0]                    spike_count_o
);

  localparam int unsigned NW = $clog2(NUM_NEURONS);
  localparam int unsigned AW = $clog2(NUM_AXONS);
  localparam logic [NW-1:0] LAST_IDX = NW'(NUM_NEURONS - 1);

  seq_state_e             state_q, state_d;
  logic [NW-1:0]          idx_q, idx_d;
  logic [NUM_NEURONS-1:0] mask_q, mask_d;
  logic [SYN_W-1:0]       type_q, type_d;

  logic [POT_W-1:0]       pot_q      [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] cfg_mask_q [NUM_AXONS];
  logic [SYN_W-1:0]       cfg_type_q [NUM_AXONS];

  logic cur_conn, fifo_full, fifo_empty, fifo_pop, blocked, commit, fifo_push;

  // Current neuron is evaluated only while scanning and connected.
  assign cur_conn  = (state_q != IDLE) && mask_q[idx_q];
  assign fifo_pop  = out_ready_i && !fifo_empty;
  // A spiking neuron waits if the FIFO has no room even counting a same-cycle pop.
  assign blocked   = cur_conn && nb_spike_i && fifo_full && !fifo_pop;
  assign commit    = cur_conn && !blocked;
  assign fifo_push = commit && nb_spike_i;

  // ---------------- next-state / outputs ----------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    type_d  = type_q;
    unique case (state_q)
      IDLE: begin
        if (spike_valid_i) begin
          mask_d  = cfg_mask_q[spike_axon_i];
          type_d  = cfg_type_q[spike_axon_i];
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN, STALL: begin
        if (blocked) begin
          state_d = STALL;
        end else if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + NW'(1);
          state_d = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    spike_ready_o      = (state_q == IDLE);
    busy_o             = (state_q != IDLE);
    nb_enable_o        = cur_conn;
    nb_potential_o     = '0;
    nb_weight_select_o = '0;
    if (cur_conn) begin
      nb_potential_o     = pot_q[idx_q];
      nb_weight_select_o = syn_weight_sel(type_q);
    end
  end

  assign rd_potential_o = pot_q[rd_neuron_i];
  assign out_valid_o    = !fifo_empty;

  // ---------------- state registers ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      type_q  <= SYN_TYPE_0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      type_q  <= type_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned n = 0; n < NUM_NEURONS; n++) pot_q[n] <= '0;
    end else if (commit) begin
      pot_q[idx_q] <= nb_new_potential_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned a = 0; a < NUM_AXONS; a++) begin
        cfg_mask_q[a] <= '0;
        cfg_type_q[a] <= SYN_TYPE_0;
      end
    end else if (cfg_we_i) begin
      cfg_mask_q[cfg_axon_i] <= cfg_mask_i;
      cfg_type_q[cfg_axon_i] <= cfg_type_i;
    end
  end

  // ---------------- output spike FIFO ----------------
  spike_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(NW)
  ) u_out_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (fifo_push),
    .data_i (idx_q),
    .pop_i  (fifo_pop),
    .data_o (out_neuron_o),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // ---------------- optional spike counter ----------------
`ifdef NEURON_SEQ_SPIKE_CNT_EN
  logic [15:0] spike_cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spike_cnt_q <= '0;
    end else if (fifo_push && (spike_cnt_q != '1)) begin
      spike_cnt_q <= spike_cnt_q + 16'd1;
    end
  end
  assign spike_count_o = spike_cnt_q;
`else
  assign spike_count_o = '0;
`endif

endmodule

// File: tb/tb_neuron_core_sequencer.sv
module tb_neuron_core_sequencer;

  localparam int NN = 16;
  localparam int NA = 16;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        spike_valid;
  logic [3:0]  spike_axon;
  logic        spike_ready;
  logic        cfg_we;
  logic [3:0]  cfg_axon;
  logic [15:0] cfg_mask;
  logic [1:0]  cfg_type;
  logic [7:0]  nb_potential;
  logic [7:0]  nb_weight_select;
  logic        nb_enable;
  logic [7:0]  nb_new_potential;
  logic        nb_spike;
  logic        out_valid;
  logic [3:0]  out_neuron;
  logic        out_ready;
  logic [3:0]  rd_neuron;
  logic [7:0]  rd_potential;
  logic        busy;
  logic [15:0] spike_count;

  always #5 clk = ~clk;

  neuron_core_sequencer #(
    .NUM_NEURONS(NN),
    .NUM_AXONS  (NA),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .spike_valid_i     (spike_valid),
    .spike_axon_i      (spike_axon),
    .spike_ready_o     (spike_ready),
    .cfg_we_i          (cfg_we),
    .cfg_axon_i        (cfg_axon),
    .cfg_mask_i        (cfg_mask),
    .cfg_type_i        (cfg_type),
    .nb_potential_o    (nb_potential),
    .nb_weight_select_o(nb_weight_select),
    .nb_enable_o       (nb_enable),
    .nb_new_potential_i(nb_new_potential),
    .nb_spike_i        (nb_spike),
    .out_valid_o       (out_valid),
    .out_neuron_o      (out_neuron),
    .out_ready_i       (out_ready),
    .rd_neuron_i       (rd_neuron),
    .rd_potential_o    (rd_potential),
    .busy_o            (busy),
    .spike_count_o     (spike_count)
  );

  // Datapath behaviour: potential + 4 + 3*type (saturating at 255).
  // mode 0: never spike; mode 1: spike when result >= 20; mode 2: always spike.
  // A spiking neuron's potential resets to 0.
  int mode;
  function automatic logic [8:0] dp(input logic [7:0] pot, input logic [1:0] ty, input int md);
    int   sum;
    logic sp;
    sum = int'(pot) + 4 + 3 * int'(ty);
    if (sum > 255) sum = 255;
    sp = (md == 2) || (md == 1 && sum >= 20);
    return {sp, sp ? 8'd0 : 8'(sum)};
  endfunction

  logic [8:0] dp_res;
  always_comb begin
    dp_res           = dp(nb_potential, nb_weight_select[1:0], mode);
    nb_spike         = nb_enable & dp_res[8];
    nb_new_potential = dp_res[7:0];
  end

  // Reference model and scoreboard
  logic [15:0] ref_mask [NA];
  logic [1:0]  ref_type [NA];
  logic [7:0]  ref_pot  [NN];
  int          ref_pushes;
  int          exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          rand_ready = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted output pop is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_unexpected: got %0d expected none", out_neuron);
      end else begin
        check("out_order", 32'(out_neuron), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic cfg_write(input int a, input logic [15:0] m, input logic [1:0] t);
    cfg_we = 1'b1; cfg_axon = 4'(a); cfg_mask = m; cfg_type = t;
    tick();
    cfg_we = 1'b0;
    ref_mask[a] = m;
    ref_type[a] = t;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (!spike_ready && k < 2000) begin
      tick();
      k++;
    end
    check({"idle_", nm}, 32'(spike_ready), 32'd1);
  endtask

  // Issue one event; the reference model resolves the whole event at once.
  task automatic send_event(input int a);
    logic [8:0] r;
    wait_idle("pre_event");
    spike_valid = 1'b1;
    spike_axon  = 4'(a);
    for (int n = 0; n < NN; n++) begin
      if (ref_mask[a][n]) begin
        r = dp(ref_pot[n], ref_type[a], mode);
        ref_pot[n] = r[7:0];
        if (r[8]) begin
          exp_q.push_back(n);
          ref_pushes++;
        end
      end
    end
    tick();
    spike_valid = 1'b0;
  endtask

  task automatic check_pots(input string nm);
    for (int n = 0; n < NN; n++) begin
      rd_neuron = 4'(n);
      #1;
      check({nm, "_pot"}, 32'(rd_potential), 32'(ref_pot[n]));
    end
  endtask

  task automatic drain(input string nm);
    int k = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && k < 500) begin
      tick();
      k++;
    end
    check({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_count(input string nm);
    int e;
`ifdef NEURON_SEQ_SPIKE_CNT_EN
    e = (ref_pushes > 65535) ? 65535 : ref_pushes;
`else
    e = 0;
`endif
    check({nm, "_spike_count"}, 32'(spike_count), 32'(e));
  endtask

  task automatic ref_reset();
    for (int a = 0; a < NA; a++) begin
      ref_mask[a] = '0;
      ref_type[a] = '0;
    end
    for (int n = 0; n < NN; n++) ref_pot[n] = '0;
    exp_q.delete();
    ref_pushes = 0;
  endtask

  initial begin
    logic [17:0] en_vec, rdy_vec;
    int          en_cnt, bad_w;
    logic [7:0]  w1, w3, p4_old;

    rst = 1'b1; spike_valid = 0; spike_axon = 0; cfg_we = 0; cfg_axon = 0;
    cfg_mask = 0; cfg_type = 0; out_ready = 1'b1; rd_neuron = 0; mode = 0;
    ref_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check_pots("reset");
    check("reset_ready", 32'(spike_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_out_neuron", 32'(out_neuron), 32'd0);
    check_count("reset");

    // Single event, mask 0005 type 2, no spikes: cycle-accurate trace
    mode = 0;
    cfg_write(3, 16'h0005, 2'd2);
    send_event(3);
    en_vec = '0; rdy_vec = '0; bad_w = 0; w1 = 0; w3 = 0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      en_vec[k]  = nb_enable;
      rdy_vec[k] = spike_ready;
      if (k == 1) w1 = nb_weight_select;
      if (k == 3) w3 = nb_weight_select;
      if (!nb_enable && (nb_weight_select != 0 || nb_potential != 0)) bad_w++;
    end
    tick();
    check("enable_cycles", 32'(en_vec), 32'h0000A);
    check("ready_return", 32'(rdy_vec), 32'h20000);
    check("weight_n0", 32'(w1), 32'd2);
    check("weight_n2", 32'(w3), 32'd2);
    check("nb_zero_when_idle", 32'(bad_w), 32'd0);
    check_pots("single");

    // Second hit crosses threshold: spikes 0 then 2
    mode = 1;
    send_event(3);
    wait_idle("second_hit");
    drain("second_hit");
    check_pots("second_hit");

    // FIFO full stall at idx 4
    mode = 0;
    cfg_write(5, 16'h0010, 2'd3);
    send_event(5);
    wait_idle("prep_stall");
    p4_old = ref_pot[4];
    out_ready = 1'b0;
    mode = 2;
    cfg_write(5, 16'h001F, 2'd1);
    send_event(5);
    repeat (8) tick();
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_enable", 32'(nb_enable), 32'd1);
    check("stall_present_pot4", 32'(nb_potential), 32'(p4_old));
    check("stall_out_valid", 32'(out_valid), 32'd1);
    rd_neuron = 4'd4;
    #1;
    check("stall_pot4_held", 32'(rd_potential), 32'(p4_old));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_idle("after_stall");
    rd_neuron = 4'd4;
    #1;
    check("stall_pot4_commit", 32'(rd_potential), 32'(ref_pot[4]));
    drain("stall");
    check_pots("stall");
    check_count("stall");

    // Connectivity rewrite during own scan
    mode = 0;
    cfg_write(3, 16'h0005, 2'd2);
    send_event(3);
    tick();
    cfg_write(3, 16'h0000, 2'd0);
    wait_idle("rewrite");
    check_pots("rewrite_inflight");
    send_event(3);
    en_cnt = 0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (nb_enable) en_cnt++;
    end
    tick();
    check("rewrite_no_eval", 32'(en_cnt), 32'd0);
    check("rewrite_ready", 32'(spike_ready), 32'd1);

    // Randomized traffic with random consumer backpressure
    mode = 1;
    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        cfg_write(int'($urandom_range(0, NA - 1)), 16'($urandom()), 2'($urandom_range(0, 3)));
      send_event(int'($urandom_range(0, NA - 1)));
    end
    wait_idle("random");
    rand_ready = 0;
    drain("random");
    check_pots("random");
    check_count("random");

    // Reset mid-scan
    out_ready = 1'b0;
    cfg_write(7, 16'hFFFF, 2'd3);
    send_event(7);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ref_reset();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(spike_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check_pots("midrst");
    check_count("midrst");
    out_ready = 1'b1;
    cfg_write(7, 16'hFFFF, 2'd3);
    send_event(7);
    wait_idle("post_rst");
    drain("post_rst");
    check_pots("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_core_sequencer.md
# neuron_core_sequencer

Time-multiplexed controller that sits on the driving side of the neuron datapath interface (`voltage_potential`/`weight_select`/`enable` out, `new_potential`/`spike` back). It accepts incoming axon spike events, looks up which neurons the axon connects to and their synapse type, and walks the connected neurons one per cycle through a single combinational neuron datapath. It writes back each updated potential to an internal potential register file and emits output spike events through a small FIFO. It is the event-driven front end of a neuron core.

## Interface
- `NUM_NEURONS`, 16: neurons per core; power of two, ≥2.
- `NUM_AXONS`, 16: input axons; power of two, ≥2.
- `FIFO_DEPTH`, 4: output spike FIFO entries; power of two.
- `NW` = $clog2(NUM_NEURONS) and `AW` = $clog2(NUM_AXONS) are derived localparams.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: **one clock; reset is synchronous and active-high**.
- `spike_valid_i` in 1: incoming axon event valid.
- `spike_axon_i` in AW: axon index.
- `spike_ready_o` out 1: event accepted when valid&&ready.
- `cfg_we_i` in 1: connectivity write strobe.
- `cfg_axon_i` in AW: axon row to write.
- `cfg_mask_i` in NUM_NEURONS: bit n=1 connects the axon to neuron n.
- `cfg_type_i` in 2: synapse type 0..3 for the axon.
- `nb_potential_o` out 8: potential presented to the datapath.
- `nb_weight_select_o` out 8: zero-extended synapse type.
- `nb_enable_o` out 1: datapath evaluation strobe.
- `nb_new_potential_i` in 8: datapath result, same cycle.
- `nb_spike_i` in 1: datapath spike, same cycle.
- `out_valid_o` out 1: output spike event available.
- `out_neuron_o` out NW: spiking neuron index.
- `out_ready_i` in 1: consumer pops on valid&&ready.
- `rd_neuron_i` in NW: debug read index.
- `rd_potential_o` out 8: combinational read of the potential register.
- `busy_o` out 1: high outside IDLE.
- `spike_count_o` out 16: see Configuration.

## Operation
- States:
  - IDLE: `spike_ready_o`=1. On accept, latch mask row and type of `spike_axon_i` into working registers, set idx=0, go to SCAN.
  - SCAN: examine neuron idx.
    - If mask[idx]=0: no evaluation, `nb_enable_o`=0.
    - If mask[idx]=1: `nb_enable_o`=1, `nb_potential_o`=pot[idx], `nb_weight_select_o`={6'b0,type}. At the clock edge, pot[idx] ← `nb_new_potential_i`. If `nb_spike_i`=1, push idx into the FIFO.
    - After idx=NUM_NEURONS-1 is processed, go to IDLE.
  - STALL: entered instead of committing when a spike must be pushed, the FIFO is full, and there is no pop this cycle. In STALL, pot[idx] is not written; the same idx is re-presented each cycle until room exists, then it commits as in SCAN.
- A push and a pop in the same cycle are always allowed, including when the FIFO is full.
- Connectivity writes are accepted in any state and take effect on the next accept. The in-flight event uses its latched row.
- `nb_*` outputs are 0 whenever `nb_enable_o`=0.
- All arithmetic and saturation live in the datapath; the sequencer does no arithmetic on potentials.

## Timing
- Reset values:
  - state IDLE, `spike_ready_o`=1 (combinational from state), `busy_o`=0.
  - All pot[]=0, all masks=0, all types=0.
  - FIFO empty, `out_valid_o`=0, `out_neuron_o`=0, `spike_count_o`=0.
- Reset mid-scan aborts the event; no partial writeback survives.
- Event accepted at edge t: neuron n is evaluated in cycle t+1+n (without stalls) and its potential is written at the end of that cycle.
- Each event occupies NUM_NEURONS cycles of SCAN plus any stall cycles; `spike_ready_o` returns high in the cycle after the last neuron commits.
- A pushed spike is visible on `out_valid_o` one cycle after the push edge. The FIFO is first-word-fall-through and preserves order.
- `rd_potential_o` reflects a writeback one cycle after the commit edge.

## Configuration
- `NEURON_SEQ_SPIKE_CNT_EN`:
  - Defined: `spike_count_o` counts FIFO pushes and saturates at 16'hFFFF; it clears only on `rst_i`.
  - Undefined: the counter is not built and `spike_count_o` is tied to 0.

## Structure
- Package `neuron_seq_pkg`: state enum (IDLE, SCAN, STALL), 2-bit synapse type encoding constants, 8-bit potential width constant.
- Sub-module `spike_fifo`: parameterised synchronous FWFT FIFO with push/pop/full/empty and synchronous active-high reset, instantiated once for output events.

## Test plan
- Reset, then read every neuron via `rd_neuron_i` → all 0. Check `spike_ready_o`=1, `out_valid_o`=0, `busy_o`=0.
- Axon 3 mask 16'h0005 type 2; datapath model returns potential+10, no spike; one event → `nb_enable_o` high only in cycles t+1 and t+3 with `nb_weight_select_o`=2. Then pot[0]=pot[2]=10, others 0, and `spike_ready_o` returns high at t+17.
- Model spikes whenever result ≥20; axon 3 hit twice → second event pushes 0 then 2; outputs pop in order 0, 2.
- FIFO_DEPTH=4, `out_ready_i`=0, mask 16'h001F, all neurons spike → four pushes, then STALL at idx 4 with pot[4] unchanged. Raise `out_ready_i` for one cycle → idx 4 commits and the event completes.
- Rewrite axon 3 mask to 16'h0000 during its own scan → in-flight event still uses the old mask; the next event evaluates no neurons.
- With `NEURON_SEQ_SPIKE_CNT_EN`, five spikes → `spike_count_o`=5. Without the macro it stays 0. Assert `rst_i` mid-scan → state IDLE and all potentials 0 next cycle.
